sim_equiv_checker: RTL and testbench

- Sequential random-simulation equivalence engine for the combinational netlist pairs the team generates (golden vs revised circuit).
- Produces LFSR input patterns and drives the same pattern into both circuits.
- Compares their outputs after a configurable latency, compacts each output stream into a MISR signature, and reports the first failing pattern.
- Sits beside the netlist pair in the simulation/emulation harness; controlled by a start/done handshake.

---
 rtl/sim_equiv_checker.sv | 183 ++++++++++++++++++
 tb/tb_sim_equiv_checker.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_equiv_checker.sv
// Random-simulation equivalence engine: drives LFSR patterns into a golden/revised
// netlist pair, compares the outputs after a fixed latency and compacts them into MISRs.
module sim_equiv_checker #(
    parameter int                NUM_IN    = 33,
    parameter int                NUM_OUT   = 25,
    parameter int                CNT_W     = 16,
    parameter int                DUT_LAT   = 1,
    parameter logic [NUM_IN-1:0] LFSR_TAPS = 33'h1_0008_0000,
    parameter int                SIG_W     = 32,
    parameter logic [SIG_W-1:0]  MISR_POLY = 32'h04C1_1DB7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_patterns,
    input  logic [NUM_IN-1:0]  seed,
    input  logic               stop_on_fail,
    output logic [NUM_IN-1:0]  pat_out,
    input  logic [NUM_OUT-1:0] gold_out,
    input  logic [NUM_OUT-1:0] rev_out,
    output logic               busy,
    output logic               done,
    output logic               mismatch,
    output logic [NUM_OUT-1:0] fail_mask,
    output logic [CNT_W-1:0]   first_fail_idx,
    output logic [NUM_IN-1:0]  first_fail_pat,
    output logic [CNT_W-1:0]   checked,
    output logic [SIG_W-1:0]   misr_gold,
    output logic [SIG_W-1:0]   misr_rev
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int PD = (DUT_LAT == 0) ? 1 : DUT_LAT;

    state_t             r_state;
    state_t             w_next;
    logic [NUM_IN-1:0]  r_lfsr;
    logic [CNT_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_num;
    logic               r_stop;
    logic               r_mismatch;
    logic [NUM_OUT-1:0] r_fail_mask;
    logic [CNT_W-1:0]   r_ff_idx;
    logic [NUM_IN-1:0]  r_ff_pat;
    logic [CNT_W-1:0]   r_checked;
    logic [SIG_W-1:0]   r_misr_gold;
    logic [SIG_W-1:0]   r_misr_rev;

    logic               w_issue;
    logic               w_last;
    logic [NUM_IN-1:0]  w_lfsr_next;
    logic               w_cmp;
    logic [CNT_W-1:0]   w_cmp_idx;
    logic [NUM_IN-1:0]  w_cmp_pat;
    logic               w_inflight;
    logic [NUM_OUT-1:0] w_diff;
    logic               w_first;
    logic               w_stop_now;
    logic               w_accept;

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] m,
                                                  input logic [NUM_OUT-1:0] x);
        return (m << 1) ^ (m[SIG_W-1] ? MISR_POLY : '0) ^ SIG_W'(x);
    endfunction

    assign w_issue     = (r_state == S_RUN);
    assign w_last      = (r_idx == r_num - CNT_W'(1));
    assign w_lfsr_next = {r_lfsr[NUM_IN-2:0], ^(r_lfsr & LFSR_TAPS)};
    assign w_accept    = (r_state == S_IDLE) && start;

    // Delay line aligning each issued pattern with the circuit outputs it produced.
    if (DUT_LAT == 0) begin : g_lat0
        assign w_cmp      = w_issue;
        assign w_cmp_idx  = r_idx;
        assign w_cmp_pat  = r_lfsr;
        assign w_inflight = 1'b0;
    end else begin : g_pipe
        logic [PD-1:0]     r_dv;
        logic [CNT_W-1:0]  r_di [PD];
        logic [NUM_IN-1:0] r_dp [PD];

        always_ff @(posedge clk) begin
            if (rst || w_stop_now) r_dv <= '0;
            else                   r_dv <= PD'({r_dv, w_issue});
        end

        // NOTE: only the valid bits are reset; index/pattern payload is never read unless qualified by its valid bit.
        always_ff @(posedge clk) begin
            r_di[0] <= r_idx;
            r_dp[0] <= r_lfsr;
            for (int k = 1; k < PD; k++) begin
                r_di[k] <= r_di[k-1];
                r_dp[k] <= r_dp[k-1];
            end
        end

        assign w_cmp      = r_dv[PD-1];
        assign w_cmp_idx  = r_di[PD-1];
        assign w_cmp_pat  = r_dp[PD-1];
        assign w_inflight = |(r_dv & ~(PD'(1) << (PD-1)));
    end

    assign w_diff     = gold_out ^ rev_out;
    assign w_first    = w_cmp && (w_diff != '0) && !r_mismatch;
    assign w_stop_now = w_first && r_stop;

    // NOTE: every output of this block gets its default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (num_patterns == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                if (w_stop_now)  w_next = S_DONE;
                else if (w_last) w_next = (DUT_LAT == 0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: if (w_stop_now || !w_inflight) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lfsr      <= '0;
            r_idx       <= '0;
            r_num       <= '0;
            r_stop      <= 1'b0;
            r_mismatch  <= 1'b0;
            r_fail_mask <= '0;
            r_ff_idx    <= '0;
            r_ff_pat    <= '0;
            r_checked   <= '0;
            r_misr_gold <= '1;
            r_misr_rev  <= '1;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_num       <= num_patterns;
                r_idx       <= '0;
                r_stop      <= stop_on_fail;
                r_mismatch  <= 1'b0;
                r_fail_mask <= '0;
                r_ff_idx    <= '0;
                r_ff_pat    <= '0;
                r_checked   <= '0;
                r_misr_gold <= '1;
                r_misr_rev  <= '1;
                if (num_patterns != '0) r_lfsr <= (seed == '0) ? NUM_IN'(1) : seed;
            end else begin
                if (w_issue && !w_last && !w_stop_now) begin
                    r_lfsr <= w_lfsr_next;
                    r_idx  <= r_idx + CNT_W'(1);
                end
                if (w_cmp) begin
                    if (r_checked != '1) r_checked <= r_checked + CNT_W'(1);
                    r_fail_mask <= r_fail_mask | w_diff;
                    r_misr_gold <= misr_step(r_misr_gold, gold_out);
                    r_misr_rev  <= misr_step(r_misr_rev, rev_out);
                    if (w_first) begin
                        r_mismatch <= 1'b1;
                        r_ff_idx   <= w_cmp_idx;
                        r_ff_pat   <= w_cmp_pat;
                    end
                end
            end
        end
    end

    assign pat_out        = r_lfsr;
    assign busy           = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done           = (r_state == S_DONE);
    assign mismatch       = r_mismatch;
    assign fail_mask      = r_fail_mask;
    assign first_fail_idx = r_ff_idx;
    assign first_fail_pat = r_ff_pat;
    assign checked        = r_checked;
    assign misr_gold      = r_misr_gold;
    assign misr_rev       = r_misr_rev;

endmodule

// File: tb/tb_sim_equiv_checker.sv
// Bench for sim_equiv_checker: five instances (narrow LFSR, default, and latencies 0/2/3)
// checked against a run-level behavioural model plus hand-computed literals.
`timescale 1ns/1ps
module tb_sim_equiv_checker;

    localparam int NK = 5;

    function automatic int lat_of(input int k);
        case (k)
            2:       return 2;
            3:       return 0;
            4:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int ni_of(input int k);
        return (k == 0) ? 4 : 33;
    endfunction

    function automatic logic [32:0] taps_of(input int k);
        return (k == 0) ? 33'hC : 33'h1_0008_0000;
    endfunction

    function automatic logic [32:0] mask_of(input int k);
        return (33'd1 << ni_of(k)) - 33'd1;
    endfunction

    // The netlist pair: an arbitrary mixing function, with faults injected by pattern value.
    function automatic logic [24:0] circ(input logic [32:0] p);
        logic [32:0] t;
        t = p ^ (p >> 5) ^ (p << 11);
        return t[24:0] ^ {17'd0, t[32:25]};
    endfunction

    function automatic logic [24:0] inj(input logic [32:0] p, input int mode,
                                        input logic [32:0] bp, input logic [24:0] bm);
        case (mode)
            1:       return (p == bp) ? bm : 25'd0;
            2:       return (p[3:0] == 4'h5) ? (circ(~p) | 25'h1) : 25'd0;
            default: return 25'd0;
        endcase
    endfunction

    function automatic logic [32:0] lfsr_next(input logic [32:0] p, input int k);
        return ((p << 1) | 33'(^(p & taps_of(k)))) & mask_of(k);
    endfunction

    function automatic logic [32:0] first_pat(input logic [32:0] sd, input int k);
        logic [32:0] s;
        s = sd & mask_of(k);
        return (s == 0) ? 33'd1 : s;
    endfunction

    function automatic logic [32:0] gen_pat(input int k, input logic [32:0] sd, input int i);
        logic [32:0] p;
        p = first_pat(sd, k);
        for (int j = 0; j < i; j++) p = lfsr_next(p, k);
        return p;
    endfunction

    function automatic logic [31:0] misr(input logic [31:0] m, input logic [24:0] x);
        return (m << 1) ^ (m[31] ? 32'h04C1_1DB7 : 32'd0) ^ {7'd0, x};
    endfunction

    logic        clk;
    logic        rst;
    logic        start_s [NK];
    logic [15:0] num_s   [NK];
    logic [32:0] seed_s  [NK];
    logic        sof_s   [NK];
    int          inj_mode [NK];
    logic [32:0] inj_pat  [NK];
    logic [24:0] inj_mask [NK];

    logic [32:0] pat_w  [NK];
    logic        busy_w [NK];
    logic        done_w [NK];
    logic        mm_w   [NK];
    logic [24:0] fm_w   [NK];
    logic [15:0] ffi_w  [NK];
    logic [32:0] ffp_w  [NK];
    logic [15:0] chk_w  [NK];
    logic [31:0] mg_w   [NK];
    logic [31:0] mr_w   [NK];

    int          total = 0;
    int          bad   = 0;
    logic [32:0] seen [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < NK; k++) begin : g_dut
        localparam int NI = ni_of(k);
        localparam int L  = lat_of(k);
        localparam logic [NI-1:0] TP = NI'(taps_of(k));

        logic [NI-1:0] pat_l;
        logic [NI-1:0] ffp_l;
        logic [24:0]   g_l;
        logic [24:0]   r_l;
        logic [32:0]   tap_pat;

        if (L == 0) begin : g_nd
            assign tap_pat = 33'(pat_l);
        end else begin : g_d
            logic [32:0] sr [L];
            always @(posedge clk) begin
                sr[0] <= 33'(pat_l);
                for (int i = 1; i < L; i++) sr[i] <= sr[i-1];
            end
            assign tap_pat = sr[L-1];
        end

        assign g_l = circ(tap_pat);
        assign r_l = g_l ^ inj(tap_pat, inj_mode[k], inj_pat[k], inj_mask[k]);

        sim_equiv_checker #(
            .NUM_IN(NI), .NUM_OUT(25), .CNT_W(16), .DUT_LAT(L),
            .LFSR_TAPS(TP), .SIG_W(32), .MISR_POLY(32'h04C1_1DB7)
        ) u_dut (
            .clk(clk), .rst(rst), .start(start_s[k]), .num_patterns(num_s[k]),
            .seed(seed_s[k][NI-1:0]), .stop_on_fail(sof_s[k]),
            .pat_out(pat_l), .gold_out(g_l), .rev_out(r_l),
            .busy(busy_w[k]), .done(done_w[k]), .mismatch(mm_w[k]),
            .fail_mask(fm_w[k]), .first_fail_idx(ffi_w[k]), .first_fail_pat(ffp_l),
            .checked(chk_w[k]), .misr_gold(mg_w[k]), .misr_rev(mr_w[k])
        );

        assign pat_w[k] = 33'(pat_l);
        assign ffp_w[k] = 33'(ffp_l);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_reset(input int k, input string tag);
        check($sformatf("%s k%0d busy", tag, k), 64'(busy_w[k]), 64'd0);
        check($sformatf("%s k%0d done", tag, k), 64'(done_w[k]), 64'd0);
        check($sformatf("%s k%0d pat_out", tag, k), 64'(pat_w[k]), 64'd0);
        check($sformatf("%s k%0d mismatch", tag, k), 64'(mm_w[k]), 64'd0);
        check($sformatf("%s k%0d fail_mask", tag, k), 64'(fm_w[k]), 64'd0);
        check($sformatf("%s k%0d ff_idx", tag, k), 64'(ffi_w[k]), 64'd0);
        check($sformatf("%s k%0d ff_pat", tag, k), 64'(ffp_w[k]), 64'd0);
        check($sformatf("%s k%0d checked", tag, k), 64'(chk_w[k]), 64'd0);
        check($sformatf("%s k%0d misr_gold", tag, k), 64'(mg_w[k]), 64'hFFFF_FFFF);
        check($sformatf("%s k%0d misr_rev", tag, k), 64'(mr_w[k]), 64'hFFFF_FFFF);
    endtask

    // One run: the model predicts the whole run, then every cycle is compared until done+1.
    task automatic run(input int k, input int n, input logic [32:0] sd, input bit sof,
                       input bit poke, output int act_done);
        logic [32:0] pats [$];
        logic [32:0] p;
        logic [32:0] ffp;
        logic [24:0] g, r, d, fm;
        logic [31:0] mg, mr;
        int          ncmp, fidx, done_at, issue_end, lat;
        bit          mm, stopped;

        lat = lat_of(k);
        p   = first_pat(sd, k);
        for (int i = 0; i < n; i++) begin
            pats.push_back(p);
            p = lfsr_next(p, k);
        end
        mm = 0; stopped = 0; fm = '0; mg = '1; mr = '1; ncmp = 0; fidx = 0; ffp = '0;
        for (int i = 0; i < n && !stopped; i++) begin
            g = circ(pats[i]);
            r = g ^ inj(pats[i], inj_mode[k], inj_pat[k], inj_mask[k]);
            d = g ^ r;
            ncmp++;
            fm |= d;
            mg = misr(mg, g);
            mr = misr(mr, r);
            if (d != 0 && !mm) begin
                mm = 1; fidx = i; ffp = pats[i];
                if (sof) stopped = 1;
            end
        end
        if (n == 0)       done_at = 1;
        else if (stopped) done_at = fidx + 2 + lat;
        else              done_at = n + lat + 1;
        issue_end = stopped ? ((fidx + 1 + lat < n) ? fidx + 1 + lat : n) : n;

        seen.delete();
        act_done = -1;
        @(negedge clk);
        start_s[k] = 1'b1; num_s[k] = 16'(n); seed_s[k] = sd; sof_s[k] = sof;
        for (int j = 1; j <= done_at + 1; j++) begin
            @(negedge clk);
            start_s[k] = poke && (j == 2);
            if (poke && j == 2) begin
                num_s[k] = 16'(n + 5); seed_s[k] = ~sd; sof_s[k] = ~sof;
            end
            check($sformatf("k%0d c%0d busy", k, j), 64'(busy_w[k]), 64'(n > 0 && j < done_at));
            check($sformatf("k%0d c%0d done", k, j), 64'(done_w[k]), 64'(j == done_at));
            if (done_w[k] && act_done < 0) act_done = j;
            if (j <= issue_end) begin
                check($sformatf("k%0d c%0d pat_out", k, j), 64'(pat_w[k]), 64'(pats[j-1]));
                seen.push_back(pat_w[k]);
            end else if (!stopped && n > 0 && j < done_at) begin
                check($sformatf("k%0d c%0d drain pat_out", k, j), 64'(pat_w[k]), 64'(pats[n-1]));
            end
            if (j == done_at) begin
                check($sformatf("k%0d checked", k), 64'(chk_w[k]), 64'(ncmp));
                check($sformatf("k%0d mismatch", k), 64'(mm_w[k]), 64'(mm));
                check($sformatf("k%0d fail_mask", k), 64'(fm_w[k]), 64'(fm));
                check($sformatf("k%0d ff_idx", k), 64'(ffi_w[k]), 64'(fidx));
                check($sformatf("k%0d ff_pat", k), 64'(ffp_w[k]), 64'(ffp));
                check($sformatf("k%0d misr_gold", k), 64'(mg_w[k]), 64'(mg));
                check($sformatf("k%0d misr_rev", k), 64'(mr_w[k]), 64'(mr));
            end
        end
        start_s[k] = 1'b0;
    endtask

    task automatic rst_mid_drain();
        @(negedge clk);
        inj_mode[4] = 2;
        start_s[4] = 1'b1; num_s[4] = 16'd4; seed_s[4] = 33'h1_F0F0; sof_s[4] = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            start_s[4] = 1'b0;
        end
        check("drain busy before rst", 64'(busy_w[4]), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset(4, "after rst");
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check($sformatf("post rst c%0d done", j), 64'(done_w[4]), 64'd0);
            check($sformatf("post rst c%0d busy", j), 64'(busy_w[4]), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ad, ad3, ad4;
        logic [32:0] sd, p4, p6;
        logic [32:0] exp1 [5];

        rst = 1'b1;
        for (int k = 0; k < NK; k++) begin
            start_s[k] = 1'b0; num_s[k] = '0; seed_s[k] = '0; sof_s[k] = 1'b0;
            inj_mode[k] = 0; inj_pat[k] = '0; inj_mask[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NK; k++) check_reset(k, "reset");

        // Narrow LFSR, identical circuits: hand-derived sequence 1,2,4,9,3.
        exp1 = '{33'd1, 33'd2, 33'd4, 33'd9, 33'd3};
        run(0, 5, 33'd1, 1'b0, 1'b0, ad);
        check("t1 seen count", 64'(seen.size()), 64'd5);
        for (int i = 0; i < seen.size() && i < 5; i++)
            check($sformatf("t1 pat[%0d]", i), 64'(seen[i]), 64'(exp1[i]));
        check("t1 done latency", 64'(ad), 64'd7);
        check("t1 checked", 64'(chk_w[0]), 64'd5);
        check("t1 misr equal", 64'(mg_w[0] == mr_w[0]), 64'd1);

        // Bit 7 flipped on pattern index 3 only.
        sd = 33'h1_2345_6789;
        p4 = gen_pat(1, sd, 3);
        inj_mode[1] = 1; inj_pat[1] = p4; inj_mask[1] = 25'h80;
        run(1, 10, sd, 1'b0, 1'b0, ad);
        check("t2 mismatch", 64'(mm_w[1]), 64'd1);
        check("t2 ff_idx", 64'(ffi_w[1]), 64'd3);
        check("t2 ff_pat", 64'(ffp_w[1]), 64'(p4));
        check("t2 fail_mask", 64'(fm_w[1]), 64'h80);
        check("t2 checked", 64'(chk_w[1]), 64'd10);
        check("t2 misr differ", 64'(mg_w[1] != mr_w[1]), 64'd1);
        check("t2 done latency", 64'(ad), 64'd12);

        // Same fault, stop_on_fail with two-cycle latency.
        inj_mode[2] = 1; inj_pat[2] = p4; inj_mask[2] = 25'h80;
        run(2, 10, sd, 1'b1, 1'b0, ad);
        check("t3 checked", 64'(chk_w[2]), 64'd4);
        check("t3 ff_idx", 64'(ffi_w[2]), 64'd3);
        check("t3 done latency", 64'(ad), 64'd7);

        // Zero seed, then a zero-length run that must clear previous results.
        inj_mode[1] = 0;
        run(1, 3, 33'd0, 1'b0, 1'b0, ad);
        check("t4 first pat", 64'(seen.size() > 0 ? seen[0] : 33'd0), 64'd1);
        inj_mode[1] = 1;
        run(1, 10, sd, 1'b0, 1'b0, ad);
        run(1, 0, sd, 1'b0, 1'b0, ad);
        check("t4 zero done latency", 64'(ad), 64'd1);
        check("t4 zero mismatch", 64'(mm_w[1]), 64'd0);
        check("t4 zero checked", 64'(chk_w[1]), 64'd0);

        // Start pulsed mid-run is ignored; reset mid-drain abandons the run.
        inj_mode[1] = 2;
        run(1, 12, 33'h0_0BAD_CAFE, 1'b0, 1'b1, ad);
        rst_mid_drain();

        // Failure on the last pattern at latency 0 and 3.
        sd = 33'h0_DEAD_BEEF;
        p6 = gen_pat(3, sd, 5);
        for (int k = 3; k < 5; k++) begin
            inj_mode[k] = 1; inj_pat[k] = p6; inj_mask[k] = 25'h1_0001;
        end
        run(3, 6, sd, 1'b0, 1'b0, ad3);
        check("t6 lat0 ff_idx", 64'(ffi_w[3]), 64'd5);
        run(4, 6, sd, 1'b0, 1'b0, ad4);
        check("t6 lat3 ff_idx", 64'(ffi_w[4]), 64'd5);
        check("t6 done latency delta", 64'(ad4 - ad3), 64'd3);

        // Randomised runs with sparse pattern-dependent faults.
        for (int it = 0; it < 24; it++) begin
            int  k, n;
            bit  sof, poke;
            k    = int'($urandom_range(1, 4));
            n    = int'($urandom_range(1, 40));
            sof  = 1'($urandom_range(0, 1));
            poke = (n >= 3) && ($urandom_range(0, 3) == 0);
            sd   = {1'($urandom), 32'($urandom)};
            inj_mode[k] = 2;
            run(k, n, sd, sof, poke, ad);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
